stream_decryptor: RTL

STREAM_DECRYPTOR -- requirements
Module: stream_decryptor

---
 rtl/stream_decryptor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stream_decryptor.sv
// Stream decryptor: subtracts a cycled secret key from each ciphertext byte through a
// single-entry valid/ready output register. Optional XOR checksum under STREAM_DEC_CHECKSUM_EN.
module stream_decryptor #(
    parameter int MSG_LEN = 23,
    parameter int SEC_LEN = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*SEC_LEN-1:0] key_in,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 busy
`ifdef STREAM_DEC_CHECKSUM_EN
    ,
    output logic                 chk_valid,
    output logic [7:0]           chk
`endif
);

    localparam int CNT_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int IDX_W = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [8*SEC_LEN-1:0] key_r;
    logic [CNT_W-1:0]     byte_cnt_r;
    logic [IDX_W-1:0]     key_idx_r;
    logic                 m_valid_r;
    logic [7:0]           m_data_r;
    logic                 m_last_r;
    logic                 s_fire_s;
    logic                 m_fire_s;
    logic                 start_fire_s;
    logic [7:0]           plain_s;

    // The output register may refill in the same cycle it is drained, so ready looks at m_ready.
    assign s_ready      = (state_r == RUN) && (!m_valid_r || m_ready);
    assign s_fire_s     = s_valid && s_ready;
    assign m_fire_s     = m_valid_r && m_ready;
    assign start_fire_s = (state_r == IDLE) && start;
    assign plain_s      = s_data - key_r[{key_idx_r, 3'b000} +: 8];

    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign busy    = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (s_fire_s && (byte_cnt_r == CNT_LAST)) state_next_s = DRAIN;
                else                                      state_next_s = RUN;
            end
            DRAIN: begin
                if (m_fire_s) state_next_s = IDLE;
                else          state_next_s = DRAIN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Key latch, byte/key counters and the single-entry output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r      <= '0;
            byte_cnt_r <= '0;
            key_idx_r  <= '0;
            m_valid_r  <= 1'b0;
            m_data_r   <= 8'd0;
            m_last_r   <= 1'b0;
        end else begin
            if (start_fire_s) begin
                key_r      <= key_in;
                byte_cnt_r <= '0;
                key_idx_r  <= '0;
            end else if (s_fire_s) begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                key_idx_r  <= (key_idx_r == IDX_LAST) ? '0 : key_idx_r + IDX_W'(1);
            end
            if (s_fire_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= plain_s;
                m_last_r  <= (byte_cnt_r == CNT_LAST);
            end else if (m_fire_s) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end
        end
    end

`ifdef STREAM_DEC_CHECKSUM_EN
    logic [7:0] chk_r;
    logic       chk_valid_r;

    assign chk       = chk_r;
    assign chk_valid = chk_valid_r;

    // Running XOR of plaintext; the pulse lands in the first IDLE cycle after the message drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_r       <= 8'd0;
            chk_valid_r <= 1'b0;
        end else begin
            chk_valid_r <= (state_r == DRAIN) && m_fire_s;
            if (start_fire_s) begin
                chk_r <= 8'd0;
            end else if (s_fire_s) begin
                chk_r <= chk_r ^ plain_s;
            end
        end
    end
`endif

endmodule
